matrix_mem_responder: RTL and testbench
=======================================

# matrix_mem_responder

Memory-side responder for one matrix port of the matrix multiplier: a ROWS×COLS matrix store answering the multiplier's read/write-enable plus row/column address interface. A host streaming port loads an operand matrix in row-major order and dumps a result matrix in row-major order. One instance serves each of matrices A, B and C. Engine accesses are honoured only while the block is idle.

## Interface
- DATA_WIDTH, 8, element width in bits
- ROWS, 16, number of matrix rows (1..16)
- COLS, 16, number of matrix columns (1..16)

- clk  in  1  single clock, all logic on the rising edge
- reset  in  1  synchronous reset, active-high
- en_ReadMat  in  1  engine read request
- en_WriteMat  in  1  engine write request
- rowAddr  in  4  engine row address
- colAddr  in  4  engine column address
- writeData  in  DATA_WIDTH  engine write data
- readData  out  DATA_WIDTH  engine read data, registered
- addrError  out  1  one-cycle pulse: engine access had rowAddr≥ROWS or colAddr≥COLS
- accessDenied  out  1  one-cycle pulse: engine access arrived while busy
- load_start  in  1  pulse: begin a host load
- dump_start  in  1  pulse: begin a host dump
- host_in_valid  in  1  load element valid
- host_in_ready  out  1  load element accepted
- host_in_data  in  DATA_WIDTH  load element
- host_out_valid  out  1  dump element valid
- host_out_ready  in  1  dump sink ready
- host_out_data  out  DATA_WIDTH  dump element
- host_out_last  out  1  marks element (ROWS-1,COLS-1) of the dump
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a load or dump completes

## Operation
- States: CLEAR (only when the configuration macro is defined), IDLE, LOAD, DUMP.
- Element order for load and dump is row-major:
  - The column counter wraps from COLS-1 to 0 and then increments the row counter.
  - Both counters return to 0 on entry to LOAD or DUMP.
- IDLE:
  - An engine write with in-range addresses stores writeData at (rowAddr, colAddr).
  - An engine read loads readData with the stored element.
  - Read and write together at the same address: write is performed; readData returns the old value (read-before-write).
  - Out-of-range read returns 0. Out-of-range write is dropped. Either raises addrError.
  - load_start enters LOAD. dump_start enters DUMP. If both are high in the same cycle, load wins.
- LOAD:
  - host_in_ready is 1.
  - Each cycle with host_in_valid && host_in_ready writes host_in_data at the counter position.
  - The handshake on (ROWS-1, COLS-1) returns to IDLE and pulses done.
- DUMP:
  - Reads are prefetched so that full throughput (one element per cycle) is sustained while host_out_ready is held high.
  - host_out_data and host_out_last are stable while host_out_valid && !host_out_ready.
  - The handshake on the last element returns to IDLE and pulses done. host_out_valid drops the same edge.
- Busy behaviour:
  - Engine accesses in any state other than IDLE are ignored and pulse accessDenied.
  - readData holds its value.
  - load_start and dump_start outside IDLE are ignored.
- Reset:
  - Reset mid-operation abandons the transfer. Counters clear to 0.
  - Stored contents are not erased unless the macro is defined.
- Reset values: readData=0, addrError=0, accessDenied=0, host_in_ready=0, host_out_valid=0, host_out_data=0, host_out_last=0, done=0; busy=0 without the macro, busy=1 with it.

## Timing
- Engine read latency is 1: request sampled at edge N, readData valid after edge N. Without a read, readData holds its value.
- Engine write takes effect at edge N; a read at N+1 returns the new value.
- addrError and accessDenied are registered: high for exactly the cycle after the offending request.
- load_start at edge N: host_in_ready=1 after edge N. The first element can be accepted at edge N+1.
- dump_start at edge N: host_out_valid=1 after edge N+2; elements then follow back-to-back while ready is held.
- done is high for one cycle, after the edge of the final handshake.

## Configuration
- MATRIX_MEM_CLEAR_EN defined:
  - After reset, the block enters CLEAR and writes 0 to all ROWS×COLS entries, one per cycle, busy=1.
  - It enters IDLE after ROWS×COLS cycles with no done pulse.
  - Engine accesses during CLEAR pulse accessDenied.
- Not defined: reset goes directly to IDLE and contents are unchanged.

## Structure
- Package matrix_mem_pkg:
  - state enum (CLEAR, IDLE, LOAD, DUMP)
  - MAX_DIM=16, ADDR_WIDTH=4
  - row-major linear-index helper (row*COLS+col)
- Sub-module matrix_mem_array: single-port ROWS×COLS×DATA_WIDTH RAM with registered read port and read-before-write behaviour. The FSM multiplexes engine, load, dump and clear accesses onto it.

## Test plan
- Load 16×16 with values 0..255, host_in_valid held high: done pulses 256 cycles after the first accept. Engine read (3,5) returns 0x35 one cycle later.
- Engine write 0xA5 at (15,15), then dump with host_out_ready toggling 1/0: 256 elements in row-major order; last=1 only on 0xA5; data held stable during stalls.
- Engine read at rowAddr=15 with ROWS=8: readData=0 and a single-cycle addrError pulse. An out-of-range write leaves contents unchanged.
- Engine read during LOAD: accessDenied pulses and readData keeps its previous value. load_start and dump_start in the same IDLE cycle: LOAD entered.
- Reset asserted at element 100 of a dump: host_out_valid=0 the next cycle, busy=0, stored data intact (macro undefined).
- With MATRIX_MEM_CLEAR_EN: busy stays high for 256 cycles after reset; then engine reads of any in-range address return 0.

Source files
------------

// File: rtl/matrix_mem_pkg.sv
// matrix_mem_pkg
//   Shared types and helpers for the matrix memory responder.
//   - state_t   : controller states (CLEAR is only reachable when the
//                 MATRIX_MEM_CLEAR_EN macro is defined)
//   - MAX_DIM   : largest supported row/column count
//   - ADDR_WIDTH: width of the engine row/column addresses
//   - lin_idx() : row-major linear index (row*cols + col)
package matrix_mem_pkg;

    localparam int MAX_DIM    = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int IDX_WIDTH  = 2 * ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DUMP  = 2'd3
    } state_t;

    function automatic logic [IDX_WIDTH-1:0] lin_idx(
        input logic [ADDR_WIDTH-1:0] row,
        input logic [ADDR_WIDTH-1:0] col,
        input int                    cols
    );
        return IDX_WIDTH'(int'(row) * cols + int'(col));
    endfunction

endpackage

// File: rtl/matrix_mem_array.sv
// matrix_mem_array
//   Single-port matrix store with a registered read port. A read and a
//   write in the same cycle return the old contents (read-before-write).
//   The read register only updates when i_re is high, so it holds its
//   value otherwise.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_re     : read enable
//   i_addr   : linear element address
//   i_wdata  : write data
//   o_rdata  : registered read data
module matrix_mem_array #(
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder
//   Memory-side responder for one matrix port of the matrix multiplier.
//   Engine port: 1-cycle registered reads, writes, range/busy error pulses.
//   Host port: row-major streaming load (valid/ready in) and dump
//   (valid/ready out with a 2-deep prefetch pipeline for full throughput).
//   Optional feature: define MATRIX_MEM_CLEAR_EN to zero the whole store
//   after every reset (block stays busy for ROWS*COLS cycles).
// Ports:
//   clk, reset (sync, active-high)
//   en_ReadMat/en_WriteMat/rowAddr/colAddr/writeData -> readData,
//     addrError, accessDenied
//   load_start, host_in_valid/host_in_ready/host_in_data
//   dump_start, host_out_valid/host_out_ready/host_out_data/host_out_last
//   busy, done
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_CLEAR | zeroing the store after reset (macro builds)
// ST_IDLE  | serving engine reads/writes, waiting for host
// ST_LOAD  | accepting host elements in row-major order
// ST_DUMP  | streaming elements to the host in row-major order
module matrix_mem_responder
    import matrix_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 16,
    parameter int COLS       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_ReadMat,
    input  logic                  en_WriteMat,
    input  logic [ADDR_WIDTH-1:0] rowAddr,
    input  logic [ADDR_WIDTH-1:0] colAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  addrError,
    output logic                  accessDenied,
    input  logic                  load_start,
    input  logic                  dump_start,
    input  logic                  host_in_valid,
    output logic                  host_in_ready,
    input  logic [DATA_WIDTH-1:0] host_in_data,
    output logic                  host_out_valid,
    input  logic                  host_out_ready,
    output logic [DATA_WIDTH-1:0] host_out_data,
    output logic                  host_out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_row, r_col;
    logic                  r_issue_done, r_p1_vld, r_p1_last;
    logic                  r_rd_sel;
    logic [DATA_WIDTH-1:0] r_rd_hold;
    logic                  r_addr_err, r_acc_den, r_done;
    logic                  r_out_valid, r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_eng_req, w_oor, w_last_pos, w_load_hs;
    logic                  w_out_adv, w_issue, w_cnt_adv, w_cnt_clr, w_done_nxt;
    logic                  w_ram_we, w_ram_re;
    logic [AW-1:0]         w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata, w_ram_rdata;

    assign w_eng_req  = en_ReadMat | en_WriteMat;
    assign w_oor      = (int'(rowAddr) >= ROWS) || (int'(colAddr) >= COLS);
    assign w_last_pos = (r_row == ADDR_WIDTH'(ROWS - 1)) && (r_col == ADDR_WIDTH'(COLS - 1));
    assign w_load_hs  = (r_state == ST_LOAD) && host_in_valid;
    // Output register can take a new element when empty or being consumed.
    assign w_out_adv  = !r_out_valid || host_out_ready;
    // Issue a RAM read only when the prefetch stage will have room for it;
    // the RAM read register holds its value while no read is issued.
    assign w_issue    = (r_state == ST_DUMP) && !r_issue_done && (!r_p1_vld || w_out_adv);

    assign busy           = (r_state != ST_IDLE);
    assign host_in_ready  = (r_state == ST_LOAD);
    assign host_out_valid = r_out_valid;
    assign host_out_data  = r_out_data;
    assign host_out_last  = r_out_last;
    assign addrError      = r_addr_err;
    assign accessDenied   = r_acc_den;
    assign done           = r_done;
    // The RAM read register is shared with the dump path, so engine read
    // data is taken from it only in the cycle right after an engine read
    // and is held in r_rd_hold from then on.
    assign readData       = r_rd_sel ? w_ram_rdata : r_rd_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef MATRIX_MEM_CLEAR_EN
            r_state <= ST_CLEAR;
`else
            r_state <= ST_IDLE;
`endif
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_adv   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
`ifdef MATRIX_MEM_CLEAR_EN
            ST_CLEAR: begin
                w_cnt_adv = 1'b1;
                if (w_last_pos) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end
            end
`endif
            ST_IDLE: begin
                if (load_start) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_clr   = 1'b1;
                end else if (dump_start) begin
                    w_state_nxt = ST_DUMP;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_load_hs) begin
                    w_cnt_adv = 1'b1;
                    if (w_last_pos) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_DUMP: begin
                w_cnt_adv = w_issue;
                if (r_out_valid && host_out_ready && r_out_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = AW'(lin_idx(r_row, r_col, COLS));
        w_ram_wdata = host_in_data;
        case (r_state)
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = '0;
            end
            ST_IDLE: begin
                w_ram_addr  = AW'(lin_idx(rowAddr, colAddr, COLS));
                w_ram_we    = en_WriteMat && !w_oor;
                w_ram_re    = en_ReadMat && !w_oor;
                w_ram_wdata = writeData;
            end
            ST_LOAD:  w_ram_we = w_load_hs;
            ST_DUMP:  w_ram_re = w_issue;
            default:  w_ram_we = 1'b0;
        endcase
        if (reset) begin
            w_ram_we = 1'b0;
            w_ram_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_cnt_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_cnt_adv) begin
            if (w_last_pos) begin
                r_row <= '0;
                r_col <= '0;
            end else if (r_col == ADDR_WIDTH'(COLS - 1)) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err   <= 1'b0;
            r_acc_den    <= 1'b0;
            r_done       <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_rd_hold    <= '0;
            r_issue_done <= 1'b0;
            r_p1_vld     <= 1'b0;
            r_p1_last    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_addr_err <= w_eng_req && (r_state == ST_IDLE) && w_oor;
            r_acc_den  <= w_eng_req && (r_state != ST_IDLE);
            r_done     <= w_done_nxt;
            r_rd_sel   <= en_ReadMat && (r_state == ST_IDLE) && !w_oor;
            r_rd_hold  <= (en_ReadMat && (r_state == ST_IDLE) && w_oor) ? '0 : readData;

            if (w_cnt_clr) begin
                r_issue_done <= 1'b0;
                r_p1_vld     <= 1'b0;
            end else if (w_issue) begin
                r_p1_vld  <= 1'b1;
                r_p1_last <= w_last_pos;
                if (w_last_pos) begin
                    r_issue_done <= 1'b1;
                end
            end else if (w_out_adv) begin
                r_p1_vld <= 1'b0;
            end

            if ((r_state == ST_DUMP) && w_out_adv) begin
                r_out_valid <= r_p1_vld;
                if (r_p1_vld) begin
                    r_out_data <= w_ram_rdata;
                    r_out_last <= r_p1_last;
                end else begin
                    r_out_last <= 1'b0;
                end
            end
        end
    end

    matrix_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_matrix_mem_responder.sv
module tb_matrix_mem_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       en_rd, en_wr;
    logic [3:0] row, col;
    logic [7:0] wdata, readData;
    logic       addrError, accessDenied;
    logic       load_start, dump_start;
    logic       hin_valid, hin_ready;
    logic [7:0] hin_data;
    logic       hout_valid, hout_ready, hout_last;
    logic [7:0] hout_data;
    logic       busy, done;

    logic       b_en_rd, b_en_wr;
    logic [3:0] b_row, b_col;
    logic [7:0] b_wdata, b_readData;
    logic       b_addrError, b_accessDenied;
    logic       b_hin_ready, b_hout_valid, b_hout_last, b_busy, b_done;
    logic [7:0] b_hout_data;
    logic       b_zero = 1'b0;
    logic [7:0] b_zero8 = 8'h00;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    matrix_mem_responder #(.DATA_WIDTH(8), .ROWS(16), .COLS(16)) u0 (
        .clk(clk), .reset(reset),
        .en_ReadMat(en_rd), .en_WriteMat(en_wr), .rowAddr(row), .colAddr(col),
        .writeData(wdata), .readData(readData), .addrError(addrError),
        .accessDenied(accessDenied), .load_start(load_start), .dump_start(dump_start),
        .host_in_valid(hin_valid), .host_in_ready(hin_ready), .host_in_data(hin_data),
        .host_out_valid(hout_valid), .host_out_ready(hout_ready),
        .host_out_data(hout_data), .host_out_last(hout_last),
        .busy(busy), .done(done)
    );

    matrix_mem_responder #(.DATA_WIDTH(8), .ROWS(8), .COLS(12)) u1 (
        .clk(clk), .reset(reset),
        .en_ReadMat(b_en_rd), .en_WriteMat(b_en_wr), .rowAddr(b_row), .colAddr(b_col),
        .writeData(b_wdata), .readData(b_readData), .addrError(b_addrError),
        .accessDenied(b_accessDenied), .load_start(b_zero), .dump_start(b_zero),
        .host_in_valid(b_zero), .host_in_ready(b_hin_ready), .host_in_data(b_zero8),
        .host_out_valid(b_hout_valid), .host_out_ready(b_zero),
        .host_out_data(b_hout_data), .host_out_last(b_hout_last),
        .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd0(input logic [3:0] r, input logic [3:0] c);
        en_rd = 1'b1; row = r; col = c;
        @(negedge clk);
        en_rd = 1'b0;
    endtask

    task automatic wr0(input logic [3:0] r, input logic [3:0] c, input logic [7:0] d);
        en_wr = 1'b1; row = r; col = c; wdata = d;
        @(negedge clk);
        en_wr = 1'b0;
    endtask

    task automatic rd1(input logic [3:0] r, input logic [3:0] c);
        b_en_rd = 1'b1; b_row = r; b_col = c;
        @(negedge clk);
        b_en_rd = 1'b0;
    endtask

    task automatic wr1(input logic [3:0] r, input logic [3:0] c, input logic [7:0] d);
        b_en_wr = 1'b1; b_row = r; b_col = c; b_wdata = d;
        @(negedge clk);
        b_en_wr = 1'b0;
    endtask

    task automatic fill_sb();
        sb.delete();
        for (int i = 0; i < 256; i++) begin
            if (i == 34)       sb.push_back(8'hEE);
            else if (i == 255) sb.push_back(8'hA5);
            else               sb.push_back(8'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         cyc;
        logic       stall, slast;
        logic [7:0] sdata, exp;

        en_rd = 0; en_wr = 0; row = 0; col = 0; wdata = 0;
        load_start = 0; dump_start = 0; hin_valid = 0; hin_data = 0; hout_ready = 0;
        b_en_rd = 0; b_en_wr = 0; b_row = 0; b_col = 0; b_wdata = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_readData", 32'(readData), 32'h0);
        check("rst_addrError", 32'(addrError), 32'h0);
        check("rst_accessDenied", 32'(accessDenied), 32'h0);
        check("rst_in_ready", 32'(hin_ready), 32'h0);
        check("rst_out_valid", 32'(hout_valid), 32'h0);
        check("rst_out_data_last", 32'({hout_last, hout_data}), 32'h0);
        check("rst_done", 32'(done), 32'h0);
`ifdef MATRIX_MEM_CLEAR_EN
        check("rst_busy", 32'(busy), 32'h1);
        cnt = 0; stall = 1'b0;
        while (busy === 1'b1 && cnt < 1000) begin
            if (done === 1'b1) stall = 1'b1;
            cnt++;
            @(negedge clk);
        end
        check("clear_cycles", 32'(cnt), 32'd256);
        check("clear_no_done", 32'(stall), 32'h0);
        rd0(4'd3, 4'd5);
        check("clear_rd_3_5", 32'(readData), 32'h0);
        rd0(4'd15, 4'd15);
        check("clear_rd_15_15", 32'(readData), 32'h0);
        cnt = 0;
        while (b_busy === 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
        check("b_clear_idle", 32'(b_busy), 32'h0);
`else
        check("rst_busy", 32'(busy), 32'h0);
`endif

        wr0(4'd1, 4'd1, 8'h77);
        rd0(4'd1, 4'd1);
        check("rd_basic", 32'(readData), 32'h77);
        @(negedge clk);
        check("rd_hold_idle", 32'(readData), 32'h77);

        load_start = 1'b1; dump_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; dump_start = 1'b0;
        check("load_ready", 32'(hin_ready), 32'h1);
        check("load_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 256; k++) begin
            hin_valid = 1'b1; hin_data = k[7:0];
            if (k == 5)   check("load_wins_no_dump", 32'(hout_valid), 32'h0);
            if (k == 100) begin en_rd = 1'b1; row = 4'd1; col = 4'd1; end
            if (k == 101) begin
                check("denied_pulse", 32'(accessDenied), 32'h1);
                check("denied_rd_hold", 32'(readData), 32'h77);
            end
            if (k == 102) check("denied_once", 32'(accessDenied), 32'h0);
            if (k == 128) check("load_no_early_done", 32'(done), 32'h0);
            @(negedge clk);
            en_rd = 1'b0;
        end
        hin_valid = 1'b0;
        check("load_done", 32'(done), 32'h1);
        check("load_end_ready", 32'(hin_ready), 32'h0);
        check("load_end_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("load_done_width", 32'(done), 32'h0);

        rd0(4'd3, 4'd5);
        check("rd_3_5", 32'(readData), 32'h35);
        en_rd = 1'b1; en_wr = 1'b1; row = 4'd2; col = 4'd2; wdata = 8'hEE;
        @(negedge clk);
        en_rd = 1'b0; en_wr = 1'b0;
        check("rbw_old", 32'(readData), 32'h22);
        rd0(4'd2, 4'd2);
        check("rbw_new", 32'(readData), 32'hEE);
        wr0(4'd15, 4'd15, 8'hA5);

        fill_sb();
        hout_ready = 1'b0;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        check("dump_lat0", 32'(hout_valid), 32'h0);
        @(negedge clk);
        check("dump_lat1", 32'(hout_valid), 32'h0);
        @(negedge clk);
        check("dump_lat2", 32'(hout_valid), 32'h1);
        cyc = 0; stall = 1'b0; sdata = 8'h00; slast = 1'b0;
        while (sb.size() > 0 && cyc < 2000) begin
            hout_ready = (cyc % 2 == 0);
            if (stall) begin
                check("stall_valid", 32'(hout_valid), 32'h1);
                check("stall_data", 32'(hout_data), 32'(sdata));
                check("stall_last", 32'(hout_last), 32'(slast));
                stall = 1'b0;
            end
            if (hout_valid && hout_ready) begin
                exp = sb.pop_front();
                check("dump_data", 32'(hout_data), 32'(exp));
                check("dump_last", 32'(hout_last), 32'(sb.size() == 0));
            end else if (hout_valid) begin
                stall = 1'b1; sdata = hout_data; slast = hout_last;
            end
            @(negedge clk);
            cyc++;
        end
        hout_ready = 1'b0;
        check("dump_count_left", 32'(sb.size()), 32'h0);
        check("dump_end_valid", 32'(hout_valid), 32'h0);
        check("dump_done", 32'(done), 32'h1);
        check("dump_end_busy", 32'(busy), 32'h0);
        @(negedge clk);
        check("dump_done_width", 32'(done), 32'h0);

        fill_sb();
        hout_ready = 1'b1;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            exp = sb.pop_front();
            check("tput_elem", 32'({hout_valid, hout_data}), 32'({1'b1, exp}));
            @(negedge clk);
        end
        check("tput_elem100", 32'({hout_valid, hout_data}), 32'h164);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hout_ready = 1'b0;
        check("rst_mid_valid", 32'(hout_valid), 32'h0);
`ifdef MATRIX_MEM_CLEAR_EN
        check("rst_mid_busy", 32'(busy), 32'h1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
        rd0(4'd3, 4'd5);
        check("rst_mid_cleared", 32'(readData), 32'h0);
        cnt = 0;
        while (b_busy === 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
        check("b_idle_after_clear", 32'(b_busy), 32'h0);
`else
        check("rst_mid_busy", 32'(busy), 32'h0);
        rd0(4'd3, 4'd5);
        check("rst_mid_intact_3_5", 32'(readData), 32'h35);
        rd0(4'd15, 4'd15);
        check("rst_mid_intact_15_15", 32'(readData), 32'hA5);
`endif

        wr1(4'd1, 4'd1, 8'h5A);
        wr1(4'd2, 4'd0, 8'h20);
        wr1(4'd7, 4'd11, 8'h7B);
        rd1(4'd1, 4'd1);
        check("b_rd_basic", 32'(b_readData), 32'h5A);
        rd1(4'd8, 4'd0);
        check("b_oor_row_data", 32'(b_readData), 32'h0);
        check("b_oor_row_err", 32'(b_addrError), 32'h1);
        @(negedge clk);
        check("b_oor_err_pulse", 32'(b_addrError), 32'h0);
        rd1(4'd7, 4'd11);
        check("b_corner_data", 32'(b_readData), 32'h7B);
        check("b_corner_no_err", 32'(b_addrError), 32'h0);
        wr1(4'd1, 4'd12, 8'h99);
        check("b_oor_col_wr_err", 32'(b_addrError), 32'h1);
        rd1(4'd2, 4'd0);
        check("b_oor_wr_dropped", 32'(b_readData), 32'h20);
        rd1(4'd15, 4'd3);
        check("b_oor_rd15_data", 32'(b_readData), 32'h0);
        check("b_oor_rd15_err", 32'(b_addrError), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
